// File: rtl/control_unit.sv
// Main opcode decoder for the single-issue datapath: combinational decode into a
// registered control word with stall hold, flush bubble and illegal-opcode flag.
module control_unit #(
  parameter int OPW    = 6,
  parameter int ALUOPW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [OPW-1:0]    OpCode,
  output logic              RegWrite,
  output logic [ALUOPW-1:0] ALUOp,
  output logic              RegDst,
  output logic              ALUSrc,
  output logic              MemWrite,
  output logic              MemRead,
  output logic              MemtoReg,
  output logic              out_valid,
  output logic              illegal
);

  typedef struct packed {
    logic              reg_write;
    logic [ALUOPW-1:0] alu_op;
    logic              reg_dst;
    logic              alu_src;
    logic              mem_write;
    logic              mem_read;
    logic              mem_to_reg;
    logic              valid;
    logic              illegal;
  } ctrl_t;

  ctrl_t dec;
  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  always_comb begin
    dec = '0;
    case (OpCode)
      OPW'(0): begin
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOPW'(2'b10);
        dec.reg_dst   = 1'b1;
      end
      OPW'(4): begin
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOPW'(2'b00);
        dec.alu_src   = 1'b1;
      end
      OPW'(12): begin
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOPW'(2'b01);
        dec.alu_src   = 1'b1;
      end
      OPW'(13): begin
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOPW'(2'b11);
        dec.alu_src   = 1'b1;
      end
      OPW'(16): begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
      end
      OPW'(17): begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Flush wins over stall; idle cycles load an all-zero word so nothing downstream fires.
  always_comb begin
    ctrl_d = ctrl_q;
    if (flush) begin
      ctrl_d = '0;
    end else if (!stall) begin
      if (in_valid) begin
        ctrl_d       = dec;
        ctrl_d.valid = 1'b1;
      end else begin
        ctrl_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ctrl_q <= '0;
    else     ctrl_q <= ctrl_d;
  end

  assign RegWrite  = ctrl_q.reg_write;
  assign ALUOp     = ctrl_q.alu_op;
  assign RegDst    = ctrl_q.reg_dst;
  assign ALUSrc    = ctrl_q.alu_src;
  assign MemWrite  = ctrl_q.mem_write;
  assign MemRead   = ctrl_q.mem_read;
  assign MemtoReg  = ctrl_q.mem_to_reg;
  assign out_valid = ctrl_q.valid;
  assign illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, full opcode sweep,
// and a randomized run against a behavioural model with invariant checks.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic [5:0] OpCode = '0;
  logic       RegWrite, RegDst, ALUSrc, MemWrite, MemRead, MemtoReg, out_valid, illegal;
  logic [1:0] ALUOp;

  int checks = 0;
  int failures = 0;

  control_unit #(.OPW(6), .ALUOPW(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .OpCode(OpCode), .RegWrite(RegWrite), .ALUOp(ALUOp), .RegDst(RegDst),
    .ALUSrc(ALUSrc), .MemWrite(MemWrite), .MemRead(MemRead), .MemtoReg(MemtoReg),
    .out_valid(out_valid), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Observed word: {RegWrite, ALUOp[1:0], RegDst, ALUSrc, MemWrite, MemRead, MemtoReg, out_valid, illegal}
  logic [9:0] obs;
  assign obs = {RegWrite, ALUOp, RegDst, ALUSrc, MemWrite, MemRead, MemtoReg, out_valid, illegal};

  localparam logic [9:0] W_ZERO = 10'b0_00_0_0_0_0_0_0_0;
  localparam logic [9:0] W_R    = 10'b1_10_1_0_0_0_0_1_0;
  localparam logic [9:0] W_ADDI = 10'b1_00_0_1_0_0_0_1_0;
  localparam logic [9:0] W_SUBI = 10'b1_01_0_1_0_0_0_1_0;
  localparam logic [9:0] W_ORI  = 10'b1_11_0_1_0_0_0_1_0;
  localparam logic [9:0] W_LW   = 10'b1_00_0_1_0_1_1_1_0;
  localparam logic [9:0] W_SW   = 10'b0_00_0_1_1_0_0_1_0;
  localparam logic [9:0] W_ILL  = 10'b0_00_0_0_0_0_0_1_1;

  typedef struct {
    logic       rst;
    logic       in_valid;
    logic       stall;
    logic       flush;
    logic [5:0] op;
    logic [9:0] exp;
    string      name;
  } vec_t;

  // Spec decode table as a lookup, valid instruction assumed.
  function automatic logic [9:0] spec_word(input logic [5:0] op);
    case (op)
      6'd0:    return W_R;
      6'd4:    return W_ADDI;
      6'd12:   return W_SUBI;
      6'd13:   return W_ORI;
      6'd16:   return W_LW;
      6'd17:   return W_SW;
      default: return W_ILL;
    endcase
  endfunction

  task automatic drive(input logic r, input logic v, input logic s, input logic f, input logic [5:0] op);
    rst = r; in_valid = v; stall = s; flush = f; OpCode = op;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, obs, exp);
    end
  endtask

  task automatic check_invariants(input int cyc);
    logic ok;
    ok = !(MemWrite && MemRead) && (!MemtoReg || MemRead) && !(MemWrite && RegWrite);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL invariant cycle %0d: got word %b expected invariants to hold", cyc, obs);
    end
  endtask

  initial begin
    vec_t vecs[$];
    logic [9:0] model;
    int n_illegal;

    vecs.push_back('{1, 1, 0, 0, 6'd0,  W_ZERO, "reset1"});
    vecs.push_back('{1, 1, 0, 0, 6'd0,  W_ZERO, "reset2"});
    vecs.push_back('{0, 1, 0, 0, 6'd0,  W_R,    "rtype_after_reset"});
    vecs.push_back('{0, 1, 0, 0, 6'd4,  W_ADDI, "addi"});
    vecs.push_back('{0, 1, 0, 0, 6'd12, W_SUBI, "subi"});
    vecs.push_back('{0, 1, 0, 0, 6'd13, W_ORI,  "ori"});
    vecs.push_back('{0, 1, 0, 0, 6'd16, W_LW,   "lw"});
    vecs.push_back('{0, 1, 0, 0, 6'd17, W_SW,   "sw"});
    vecs.push_back('{0, 1, 0, 0, 6'd35, W_ILL,  "illegal35"});
    vecs.push_back('{0, 1, 0, 0, 6'd4,  W_ADDI, "stall_load"});
    vecs.push_back('{0, 1, 1, 0, 6'd16, W_ADDI, "stall1"});
    vecs.push_back('{0, 1, 1, 0, 6'd16, W_ADDI, "stall2"});
    vecs.push_back('{0, 1, 1, 0, 6'd16, W_ADDI, "stall3"});
    vecs.push_back('{0, 1, 0, 0, 6'd16, W_LW,   "stall_release"});
    vecs.push_back('{0, 1, 1, 1, 6'd0,  W_ZERO, "flush_over_stall"});
    vecs.push_back('{0, 0, 0, 0, 6'd16, W_ZERO, "idle_lw"});
    vecs.push_back('{0, 1, 0, 0, 6'd17, W_SW,   "sw_again"});
    vecs.push_back('{0, 0, 1, 0, 6'd4,  W_SW,   "stall_idle_holds"});
    vecs.push_back('{1, 1, 0, 0, 6'd4,  W_ZERO, "reset_midstream"});
    vecs.push_back('{0, 1, 0, 0, 6'd4,  W_ADDI, "resume_after_reset"});

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].in_valid, vecs[i].stall, vecs[i].flush, vecs[i].op);
      check(vecs[i].name, vecs[i].exp);
    end

    // Full opcode sweep; the illegal flag must be set on exactly 58 codes.
    n_illegal = 0;
    for (int op = 0; op < 64; op++) begin
      drive(0, 1, 0, 0, 6'(op));
      check($sformatf("sweep_op%0d", op), spec_word(6'(op)));
      if (illegal === 1'b1) n_illegal++;
    end
    checks++;
    if (n_illegal != 58) begin
      failures++;
      $display("FAIL illegal_count: got %0d expected 58", n_illegal);
    end

    // Randomized run against the behavioural model.
    drive(1, 0, 0, 0, 6'd0);
    model = W_ZERO;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic r, v, s, f;
      logic [5:0] op;
      r  = ($urandom_range(0, 31) == 0);
      v  = ($urandom_range(0, 3) != 0);
      s  = ($urandom_range(0, 4) == 0);
      f  = ($urandom_range(0, 7) == 0);
      op = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63))
                                       : spec_pick($urandom_range(0, 5));
      if (r || f)       model = W_ZERO;
      else if (s)       model = model;
      else if (!v)      model = W_ZERO;
      else              model = spec_word(op);
      drive(r, v, s, f, op);
      check($sformatf("random_cyc%0d", cyc), model);
      check_invariants(cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [5:0] spec_pick(input int unsigned idx);
    case (idx)
      0:       return 6'd0;
      1:       return 6'd4;
      2:       return 6'd12;
      3:       return 6'd13;
      4:       return 6'd16;
      default: return 6'd17;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main decoder for the single-issue datapath. Maps the 6-bit instruction OpCode to datapath control signals: RegWrite, ALUOp, RegDst, ALUSrc, MemWrite, MemRead and MemtoReg.
- Sits between instruction decode and execute. The control word is registered, with stall hold, flush/bubble insertion and illegal-opcode flagging.
- Output latency is one clock.

Parameters:
- OPW, 6, opcode width.
- ALUOPW, 2, ALUOp width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  OpCode is a real instruction this cycle.
- stall  in  1  hold the registered control word.
- flush  in  1  replace the next registered word with a bubble.
- OpCode  in  6  instruction opcode field [31:26].
- RegWrite  out  1  write register file.
- ALUOp  out  2  ALU operation class: 00 add, 01 sub, 10 use funct, 11 OR.
- RegDst  out  1  1 = rd destination, 0 = rt.
- ALUSrc  out  1  1 = sign-extended immediate, 0 = rt.
- MemWrite  out  1  data memory write.
- MemRead  out  1  data memory read.
- MemtoReg  out  1  1 = writeback from memory, 0 = from ALU.
- out_valid  out  1  registered control word is valid.
- illegal  out  1  registered opcode was not in the decode table.

Behaviour:
- Decode table is combinational. Listed as RegWrite, ALUOp, RegDst, ALUSrc, MemWrite, MemRead, MemtoReg:
  - 0 (R-type): 1, 10, 1, 0, 0, 0, 0
  - 4 (ADDI): 1, 00, 0, 1, 0, 0, 0
  - 12 (SUBI): 1, 01, 0, 1, 0, 0, 0
  - 13 (ORI): 1, 11, 0, 1, 0, 0, 0
  - 16 (LW): 1, 00, 0, 1, 0, 1, 1
  - 17 (SW): 0, 00, 0, 1, 1, 0, 0
  - Any other opcode: all zero, illegal flag set.
- Register update at each rising clk, in priority order:
  - rst=1: all outputs 0, including out_valid and illegal.
  - flush=1 (overrides stall): all outputs 0 (bubble).
  - stall=1: all outputs hold their previous values.
  - Otherwise: outputs take the decode of OpCode; out_valid=in_valid.
- If in_valid=0, all control outputs and illegal are 0. No spurious writes from idle cycles.
- An illegal opcode with in_valid=1 gives illegal=1, out_valid=1 and all control bits 0. The instruction behaves as a NOP downstream.
- Latency: OpCode presented before edge N appears on outputs after edge N.
- Invariants, required on every output cycle:
  - MemWrite and MemRead are never both 1.
  - MemtoReg=1 implies MemRead=1.
  - RegWrite=0 whenever MemWrite=1.
- Reset asserted mid-stream clears the pipeline word on that edge. Decode resumes on the first edge with rst=0.
- Outputs are driven only from flops; no combinational path from OpCode to outputs.

Test Plan:
- Reset: rst=1 for 2 cycles with OpCode=0, in_valid=1 -> all outputs 0. First edge after release gives RegWrite=1, ALUOp=10, RegDst=1, out_valid=1.
- Opcode sweep: in_valid=1, one opcode per cycle, 0, 4, 12, 13, 16, 17 -> each row of the table appears one cycle later. Examples: 16 gives MemRead=1, MemtoReg=1, ALUSrc=1; 17 gives MemWrite=1, RegWrite=0.
- Illegal: OpCode=35 with in_valid=1 -> illegal=1, out_valid=1, all control bits 0. Also sweep all 64 opcodes, checking illegal is set exactly on the 58 unlisted codes.
- Stall: load 4, then stall=1 for 3 cycles while OpCode=16 -> outputs stay at the ADDI word. Release -> LW word appears next edge.
- Flush vs stall: flush=1 and stall=1 together with OpCode=0 -> all outputs 0 next edge.
- Idle: in_valid=0 with OpCode=16 -> out_valid=0 and MemRead=0. Check the invariants on every cycle of a random run.
